// File: rtl/key_event_encoder.sv
// key_event_encoder: scans debounced key levels one index per cycle and queues press/release events in a FIFO.
module key_event_encoder #(
  parameter int KEYS  = 61,
  parameter int DEPTH = 16,
  parameter int IDX_W = 6
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [KEYS-1:0]          keys_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [IDX_W-1:0]         evt_key_o,
  output logic                     evt_press_o,
  output logic [$clog2(DEPTH):0]   evt_count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);
  logic [KEYS-1:0]  prev;
  logic [IDX_W-1:0] idx;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [IDX_W:0]   mem [DEPTH];
  logic             cur, chg, full, push, pop;
  always_comb begin
    cur  = keys_i[idx];
    chg  = cur != prev[idx];
    full = evt_count_o == (AW+1)'(DEPTH);
    push = chg && !full;
    pop  = evt_valid_o && evt_ready_i;
  end
  assign evt_valid_o = evt_count_o != '0;
  // Gating with valid keeps the head outputs at zero whenever the FIFO is empty.
  assign {evt_key_o, evt_press_o} = evt_valid_o ? mem[rd_ptr] : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev        <= keys_i;
      idx         <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      evt_count_o <= '0;
      overflow_o  <= 1'b0;
    end else begin
      idx         <= (idx == IDX_W'(KEYS-1)) ? '0 : idx + 1'b1;
      evt_count_o <= evt_count_o + (AW+1)'(push) - (AW+1)'(pop);
      if (push) begin
        prev[idx] <= cur;
        wr_ptr    <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      // A deferred change keeps prev stale so the next pass retries it.
      if (chg && full) overflow_o <= 1'b1;
    end
  end
  always_ff @(posedge clk_i)
    if (!rst_i && push) mem[wr_ptr] <= {idx, cur};
endmodule

// File: tb/tb_key_event_encoder.sv
// tb_key_event_encoder: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_key_event_encoder;
  logic        clk = 0, rst = 1, ready = 0;
  logic [60:0] keys = '0;
  logic        valid, press, ovf;
  logic [5:0]  key;
  logic [4:0]  count;
  logic [6:0]  exp_q [$];
  int          checks = 0, failures = 0;

  key_event_encoder dut (
    .clk_i(clk), .rst_i(rst), .keys_i(keys), .evt_valid_o(valid), .evt_ready_i(ready),
    .evt_key_o(key), .evt_press_o(press), .evt_count_o(count), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int k, input int p);
    exp_q.push_back({6'(k), 1'(p)});
  endtask

  // Holds reset for three edges with k0, then releases with k1; edge n after release scans idx n-1.
  task automatic do_reset(input logic [60:0] k0, input logic [60:0] k1);
    rst = 1;
    ready = 0;
    keys = k0;
    exp_q.delete();
    tick(3);
    check("rst_valid", int'(valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_ovf", int'(ovf), 0);
    check("rst_key", int'(key), 0);
    check("rst_press", int'(press), 0);
    rst = 0;
    keys = k1;
  endtask

  always @(negedge clk) begin
    logic [6:0] e;
    if (!rst && valid && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event: got key %0d press %0d expected none at %0t", key, press, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt_key", int'(key), int'(e[6:1]));
        check("evt_press", int'(press), int'(e[0]));
      end
    end
  end

  initial begin
    logic [60:0] m, k;
    int lat;
    m = '0;
    for (int i = 10; i < 30; i++) m[i] = 1'b1;

    // Single press on key 5 with ready high.
    k = '0;
    k[5] = 1'b1;
    do_reset('0, k);
    ready = 1;
    expect_evt(5, 1);
    lat = 0;
    while (!valid && lat < 62) begin
      tick(1);
      lat++;
    end
    check("press5_seen_within_62", int'(lat < 62), 1);
    check("press5_latency", lat, 6);
    tick(100);
    check("press5_drained", exp_q.size(), 0);

    // Key held through reset produces nothing until it is released.
    k = '0;
    k[60] = 1'b1;
    do_reset(k, k);
    ready = 1;
    tick(200);
    check("held60_count", int'(count), 0);
    keys[60] = 1'b0;
    expect_evt(60, 0);
    tick(70);
    check("rel60_drained", exp_q.size(), 0);

    // Twenty presses at once into a stalled FIFO, drained later in ascending order.
    do_reset('0, m);
    for (int i = 10; i < 30; i++) expect_evt(i, 1);
    tick(30);
    check("ovf_count_full", int'(count), 16);
    check("ovf_flag", int'(ovf), 1);
    tick(40);
    ready = 1;
    tick(150);
    check("ovf_drained", exp_q.size(), 0);
    check("ovf_sticky", int'(ovf), 1);

    // Pop on the edge that scans deferred key 26: no push, so 26 slips to the next pass.
    do_reset('0, m);
    for (int i = 10; i < 26; i++) expect_evt(i, 1);
    for (int i = 27; i < 30; i++) expect_evt(i, 1);
    expect_evt(26, 1);
    tick(87);
    check("pop_full_before", int'(count), 16);
    ready = 1;
    tick(1);
    check("pop_full_after", int'(count), 15);
    tick(150);
    check("pop_full_drained", exp_q.size(), 0);

    // Short glitch on key 3 while the scan is elsewhere.
    do_reset('0, '0);
    ready = 1;
    tick(20);
    keys[3] = 1'b1;
    tick(2);
    keys[3] = 1'b0;
    tick(130);
    check("glitch_count", int'(count), 0);
    check("glitch_drained", exp_q.size(), 0);

    // Reset pulse discards queued events.
    k = '0;
    for (int i = 1; i < 5; i++) k[i] = 1'b1;
    do_reset('0, k);
    tick(10);
    check("queued4_count", int'(count), 4);
    rst = 1;
    exp_q.delete();
    tick(1);
    rst = 0;
    check("pulse_valid", int'(valid), 0);
    check("pulse_count", int'(count), 0);
    check("pulse_ovf", int'(ovf), 0);
    ready = 1;
    tick(150);
    check("pulse_no_stale", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
